// File: rtl/exp_sigma_sweep.sv
// Sweeps x over [X_MIN, X_MAX], drives an external fixed-latency exp(x*sigma) datapath and
// re-aligns results into a credit-controlled output FIFO. Optional macro EXP_SWEEP_INDEX_EN: oAddr carries sweep index.
module exp_sigma_sweep #(
  parameter int X_MIN      = -26,
  parameter int X_MAX      = 26,
  parameter int X_STEP     = 1,
  parameter int X_W        = 6,
  parameter int SIGMA_W    = 18,
  parameter int DATA_W     = 17,
  parameter int PIPE_LAT   = 11,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     iStart,
  input  logic                     iAbort,
  input  logic [SIGMA_W-1:0]       iSigma,
  output logic signed [X_W-1:0]    oX,
  output logic [SIGMA_W-1:0]       oSigma,
  output logic                     oIssue,
  input  logic [DATA_W-1:0]        iExp,
  output logic [DATA_W-1:0]        oData,
  output logic [X_W-1:0]           oAddr,
  output logic                     oValid,
  input  logic                     iReady,
  output logic                     oBusy,
  output logic                     oDone
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic signed [X_W+1:0] XMIN_L  = (X_W+2)'(X_MIN);
  localparam logic signed [X_W+1:0] XMAX_L  = (X_W+2)'(X_MAX);
  localparam logic signed [X_W+1:0] STEP_L  = (X_W+2)'(X_STEP);
  localparam logic [CW:0]           DEPTH_L = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                 state;
  logic signed [X_W+1:0]  x_q;
  logic [SIGMA_W-1:0]     sigma_q;
  logic [CW-1:0]          inflight;
  logic [CW-1:0]          fifo_cnt;
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic                   tag_vld_p [PIPE_LAT];
  logic [X_W-1:0]         tag_x_p   [PIPE_LAT];
  logic [X_W-1:0]         mem_addr  [FIFO_DEPTH];
  logic [DATA_W-1:0]      mem_data  [FIFO_DEPTH];
`ifdef EXP_SWEEP_INDEX_EN
  logic [X_W-1:0]         idx_q;
`endif

  logic                   issue;
  logic                   push;
  logic                   pop;
  logic                   flush;
  logic                   last_pt;
  logic [CW:0]            credit_used;
  logic signed [X_W+1:0]  x_nxt;
  logic [CW-1:0]          inflight_nxt;
  logic [CW-1:0]          cnt_nxt;
  logic [X_W-1:0]         tag_in;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Credits cover both the tags in flight and the beats already buffered; a pop this cycle is not a credit.
  assign credit_used  = {1'b0, inflight} + {1'b0, fifo_cnt};
  assign issue        = (state == S_RUN) && !iAbort && (credit_used < DEPTH_L);
  assign flush        = iAbort && ((state == S_RUN) || (state == S_DRAIN));
  assign push         = tag_vld_p[PIPE_LAT-1];
  assign pop          = (fifo_cnt != '0) && iReady;
  assign x_nxt        = x_q + STEP_L;
  assign last_pt      = (x_nxt > XMAX_L);
  assign inflight_nxt = inflight + CW'(issue) - CW'(push);
  assign cnt_nxt      = fifo_cnt + CW'(push) - CW'(pop);

`ifdef EXP_SWEEP_INDEX_EN
  assign tag_in = idx_q;
`else
  assign tag_in = x_q[X_W-1:0];
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      x_q      <= '0;
      sigma_q  <= '0;
      inflight <= '0;
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      for (int i = 0; i < PIPE_LAT; i++) tag_vld_p[i] <= 1'b0;
`ifdef EXP_SWEEP_INDEX_EN
      idx_q    <= '0;
`endif
    end else begin
      // Tag pipe stage boundary: valid bits shift toward the FIFO, cleared on abort
      tag_vld_p[0] <= issue;
      for (int i = 1; i < PIPE_LAT; i++) tag_vld_p[i] <= flush ? 1'b0 : tag_vld_p[i-1];

      if (flush) begin
        inflight <= '0;
        fifo_cnt <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        inflight <= inflight_nxt;
        fifo_cnt <= cnt_nxt;
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      end

      case (state)
        S_IDLE: begin
          if (iStart && !iAbort) begin
            sigma_q <= iSigma;
            x_q     <= XMIN_L;
`ifdef EXP_SWEEP_INDEX_EN
            idx_q   <= '0;
`endif
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (iAbort) begin
            state <= S_IDLE;
          end else if (issue) begin
            x_q <= x_nxt;
`ifdef EXP_SWEEP_INDEX_EN
            idx_q <= idx_q + X_W'(1);
`endif
            if (last_pt) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (iAbort) state <= S_IDLE;
          else if ((inflight_nxt == '0) && (cnt_nxt == '0)) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath stage boundary: x tags travel alongside the external pipe, results land in the FIFO
  always_ff @(posedge CLK) begin
    tag_x_p[0] <= tag_in;
    for (int i = 1; i < PIPE_LAT; i++) tag_x_p[i] <= tag_x_p[i-1];
    if (push) begin
      mem_addr[wr_ptr] <= tag_x_p[PIPE_LAT-1];
      mem_data[wr_ptr] <= iExp;
    end
  end

  assign oX     = x_q[X_W-1:0];
  assign oSigma = sigma_q;
  assign oIssue = issue;
  assign oValid = (fifo_cnt != '0);
  assign oData  = oValid ? mem_data[rd_ptr] : '0;
  assign oAddr  = oValid ? mem_addr[rd_ptr] : '0;
  assign oBusy  = (state == S_RUN) || (state == S_DRAIN);
  assign oDone  = (state == S_DONE);

endmodule

// File: tb/tb_exp_sigma_sweep.sv
// Scoreboard bench for exp_sigma_sweep: a bench datapath echoes {x,11'h0} after 11 cycles,
// a negedge monitor checks beats against a queue filled at sweep start.
module tb_exp_sigma_sweep;
  localparam int X_W = 6, SIGMA_W = 18, DATA_W = 17, PIPE_LAT = 11, FIFO_DEPTH = 16, N = 53;

  typedef struct packed {
    logic [X_W-1:0]    a;
    logic [DATA_W-1:0] d;
  } beat_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic                   start, abort, ready;
  logic [SIGMA_W-1:0]     sigma;
  logic signed [X_W-1:0]  ox;
  logic [SIGMA_W-1:0]     osig;
  logic                   oissue, ovalid, obusy, odone;
  logic [DATA_W-1:0]      iexp, odata;
  logic [X_W-1:0]         oaddr;

  logic                   start2, ready2;
  logic signed [X_W-1:0]  ox2;
  logic [SIGMA_W-1:0]     osig2;
  logic                   oissue2, ovalid2, obusy2, odone2;
  logic [DATA_W-1:0]      iexp2, odata2;
  logic [X_W-1:0]         oaddr2;

  exp_sigma_sweep dut (
    .CLK(CLK), .RST(RST), .iStart(start), .iAbort(abort), .iSigma(sigma),
    .oX(ox), .oSigma(osig), .oIssue(oissue), .iExp(iexp), .oData(odata),
    .oAddr(oaddr), .oValid(ovalid), .iReady(ready), .oBusy(obusy), .oDone(odone)
  );

  exp_sigma_sweep #(.X_MIN(-8), .X_MAX(7), .X_STEP(4)) dut2 (
    .CLK(CLK), .RST(RST), .iStart(start2), .iAbort(1'b0), .iSigma(18'h00100),
    .oX(ox2), .oSigma(osig2), .oIssue(oissue2), .iExp(iexp2), .oData(odata2),
    .oAddr(oaddr2), .oValid(ovalid2), .iReady(ready2), .oBusy(obusy2), .oDone(odone2)
  );

  // Bench model of the external datapath: result = {x, 11'h0}, PIPE_LAT cycles after issue
  logic [X_W-1:0] dl  [PIPE_LAT];
  logic [X_W-1:0] dl2 [PIPE_LAT];
  always @(posedge CLK) begin
    dl[0]  <= ox;
    dl2[0] <= ox2;
    for (int i = 1; i < PIPE_LAT; i++) begin
      dl[i]  <= dl[i-1];
      dl2[i] <= dl2[i-1];
    end
  end
  assign iexp  = {dl[PIPE_LAT-1], 11'h0};
  assign iexp2 = {dl2[PIPE_LAT-1], 11'h0};

  int checks = 0, errors = 0;
  int cyc = 0, start_cyc = 0, done_cyc = 0, last_beat_cyc = 0;
  int sweep_beats = 0, issue_cnt = 0, done_cnt = 0;
  beat_t exp_q[$];
  logic  hold = 1'b0;
  beat_t held;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Monitor: credit bound, hold stability, in-order beats, done timing
  always @(negedge CLK) begin
    beat_t e;
    if (!RST) begin
      if (oissue) issue_cnt++;
      if (obusy) chk("credit_bound", longint'((issue_cnt - sweep_beats) <= FIFO_DEPTH), 1);
      if (hold) begin
        chk("hold_valid", longint'(ovalid), 1);
        chk("hold_beat", longint'({oaddr, odata}), longint'(held));
      end
      if (ovalid && ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_addr", longint'(oaddr), longint'(e.a));
          chk("beat_data", longint'(odata), longint'(e.d));
        end
        sweep_beats++;
        last_beat_cyc = cyc;
      end
      hold = ovalid && !ready;
      held = {oaddr, odata};
      if (odone) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_beats", sweep_beats, N);
        chk("done_after_last_beat", cyc - last_beat_cyc, 1);
        chk("busy_at_done", longint'(obusy), 0);
      end
    end else begin
      hold = 1'b0;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_sw(input logic [SIGMA_W-1:0] s);
    logic [X_W-1:0] xb;
    beat_t b;
    exp_q.delete();
    for (int k = 0; k < N; k++) begin
      xb = X_W'(-26 + k);
`ifdef EXP_SWEEP_INDEX_EN
      b.a = X_W'(k);
`else
      b.a = xb;
`endif
      b.d = {xb, 11'h0};
      exp_q.push_back(b);
    end
    sweep_beats = 0;
    issue_cnt   = 0;
    sigma = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    start_cyc = cyc;
    chk("first_issue", longint'(oissue), 1);
    chk("first_x", longint'(ox), -26);
    chk("busy_run", longint'(obusy), 1);
    chk("sigma_latched", longint'(osig), longint'(s));
  endtask

  task automatic wait_done();
    int d0;
    d0 = done_cnt;
    for (int t = 0; t < 3000 && done_cnt == d0; t++) tick();
    chk("done_seen", done_cnt, d0 + 1);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n, ni, nb, d0;
    int ex2 [4];
    logic seen_done2;
    ex2 = '{-8, -4, 0, 4};
    start = 0; abort = 0; ready = 1; sigma = '0; start2 = 0; ready2 = 1;

    // Reset state
    #12;
    chk("rst_valid", longint'(ovalid), 0);
    chk("rst_busy", longint'(obusy), 0);
    chk("rst_issue", longint'(oissue), 0);
    chk("rst_done", longint'(odone), 0);
    chk("rst_x", longint'(ox), 0);
    chk("rst_sigma", longint'(osig), 0);
    chk("rst_data", longint'(odata), 0);
    chk("rst_addr", longint'(oaddr), 0);
    RST = 1'b0;
    tick();

    // Back-to-back sweep with iReady held high
    start_sw(18'h10000);
    n = 1;
    while (!ovalid && n < 100) begin tick(); n++; end
    chk("first_valid_cycle", n, PIPE_LAT + 2);
    wait_done();
    chk("done_cycle", done_cyc - start_cyc + 1, N + PIPE_LAT + 2);

    // Consumer stall for 40 cycles from the first beat
    start_sw(18'h0C000);
    n = 0;
    while (!ovalid && n < 100) begin tick(); n++; end
    ready = 1'b0;
    repeat (40) tick();
    chk("stall_issue_count", issue_cnt, FIFO_DEPTH);
    chk("stall_issue_low", longint'(oissue), 0);
    chk("stall_head_data", longint'(odata), longint'({6'(-26), 11'h0}));
    ready = 1'b1;
    wait_done();

    // Random backpressure
    start_sw(18'h1F00F);
    d0 = done_cnt;
    for (int t = 0; t < 3000 && done_cnt == d0; t++) begin
      ready = 1'($urandom_range(0, 1));
      tick();
    end
    ready = 1'b1;
    chk("rand_done_seen", done_cnt, d0 + 1);
    chk("rand_queue_empty", exp_q.size(), 0);

    // Abort in the cycle of beat 20, then a fresh sweep
    start_sw(18'h05555);
    n = 0;
    while (sweep_beats < 19 && n < 200) begin tick(); n++; end
    chk("abort_head_valid", longint'(ovalid), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
    chk("abort_busy", longint'(obusy), 0);
    chk("abort_valid", longint'(ovalid), 0);
    chk("abort_issue", longint'(oissue), 0);
    chk("abort_beats", sweep_beats, 20);
    d0 = done_cnt;
    repeat (20) tick();
    chk("abort_no_done", done_cnt, d0);
    chk("abort_no_late_beat", longint'(ovalid), 0);
    start_sw(18'h2AAAA);
    wait_done();

    // Coarse-step instance: -8,-4,0,4
    ni = 0; nb = 0; seen_done2 = 1'b0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int t = 0; t < 80; t++) begin
      if (oissue2) begin
        if (ni < 4) chk("x2_issue", longint'(ox2), ex2[ni]);
        ni++;
      end
      if (ovalid2 && ready2) begin
        if (nb < 4) begin
`ifdef EXP_SWEEP_INDEX_EN
          chk("x2_addr", longint'(oaddr2), nb);
`else
          chk("x2_addr", longint'($signed(oaddr2)), ex2[nb]);
`endif
          chk("x2_data", longint'(odata2), longint'({6'(ex2[nb]), 11'h0}));
        end
        nb++;
      end
      if (odone2) begin
        chk("x2_done_beats", nb, 4);
        seen_done2 = 1'b1;
      end
      tick();
    end
    chk("x2_issues", ni, 4);
    chk("x2_beats", nb, 4);
    chk("x2_done", longint'(seen_done2), 1);

    // Asynchronous reset during DRAIN
    start_sw(18'h3FFFF);
    n = 0;
    while (sweep_beats < 45 && n < 200) begin tick(); n++; end
    chk("drain_busy", longint'(obusy), 1);
    chk("drain_no_issue", longint'(oissue), 0);
    #2 RST = 1'b1;
    #1;
    chk("arst_valid", longint'(ovalid), 0);
    chk("arst_busy", longint'(obusy), 0);
    chk("arst_data", longint'(odata), 0);
    chk("arst_addr", longint'(oaddr), 0);
    chk("arst_x", longint'(ox), 0);
    chk("arst_sigma", longint'(osig), 0);
    chk("arst_issue", longint'(oissue), 0);
    chk("arst_done", longint'(odone), 0);
    exp_q.delete();
    @(posedge CLK);
    @(posedge CLK);
    #3 RST = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", longint'(obusy), 0);
    chk("start_abort_issue", longint'(oissue), 0);
    repeat (3) tick();
    chk("start_abort_idle", longint'(obusy), 0);
    start_sw(18'h12345);
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
